// File: rtl/mipi_rx_hs_sequencer.sv
// rtl/mipi_rx_hs_sequencer.sv - D-PHY lane-0 HS-burst entry/exit sequencer for the CSI receive path
// Optional LP glitch filter: define MIPI_HS_SEQ_GLITCH_FILTER_EN.
module mipi_rx_hs_sequencer #(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int FILTER_CYCLES  = 2
) (
  input  logic        clk_i,
  input  logic        reset_in,
  input  logic        enable_i,
  input  logic        lp_p_i,
  input  logic        lp_n_i,
  output logic        aligner_reset_o,
  output logic        hs_active_o,
  output logic        hs_start_o,
  output logic        hs_end_o,
  output logic        error_o,
  output logic [2:0]  state_o,
  output logic [15:0] burst_count_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    HS_PREP   = 3'd3,
    HS_SETTLE = 3'd4,
    HS_RX     = 3'd5
  } state_t;

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  p_sync;
  logic [1:0]  n_sync;
  logic [1:0]  lp;
  state_t      state;
  state_t      state_next;
  logic [7:0]  settle_cnt;
  logic [15:0] timeout_cnt;
  logic [15:0] burst_count;
  logic        start_pulse;
  logic        end_pulse;
  logic        err_pulse;

  always_ff @(posedge clk_i) begin
    if (!reset_in) begin
      p_sync <= 2'b00;
      n_sync <= 2'b00;
    end else begin
      p_sync <= {p_sync[0], lp_p_i};
      n_sync <= {n_sync[0], lp_n_i};
    end
  end

`ifdef MIPI_HS_SEQ_GLITCH_FILTER_EN
  localparam logic [2:0] FILTER_LAST = 3'(FILTER_CYCLES - 1);

  logic       p_acc;
  logic       n_acc;
  logic [2:0] p_cnt;
  logic [2:0] n_cnt;

  // A line's accepted level moves only after the new level has held FILTER_CYCLES samples.
  always_ff @(posedge clk_i) begin
    if (!reset_in) begin
      p_acc <= 1'b0;
      n_acc <= 1'b0;
      p_cnt <= 3'd0;
      n_cnt <= 3'd0;
    end else begin
      if (p_sync[1] == p_acc) begin
        p_cnt <= 3'd0;
      end else if (p_cnt == FILTER_LAST) begin
        p_acc <= p_sync[1];
        p_cnt <= 3'd0;
      end else begin
        p_cnt <= p_cnt + 3'd1;
      end
      if (n_sync[1] == n_acc) begin
        n_cnt <= 3'd0;
      end else if (n_cnt == FILTER_LAST) begin
        n_acc <= n_sync[1];
        n_cnt <= 3'd0;
      end else begin
        n_cnt <= n_cnt + 3'd1;
      end
    end
  end

  assign lp = {p_acc, n_acc};
`else
  localparam int filter_unused = FILTER_CYCLES;

  assign lp = {p_sync[1], n_sync[1]};
`endif

  always_comb begin
    state_next  = state;
    start_pulse = 1'b0;
    end_pulse   = 1'b0;
    err_pulse   = 1'b0;
    case (state)
      IDLE: begin
        if (lp == 2'b11) state_next = STOP;
      end
      STOP: begin
        case (lp)
          2'b01: state_next = HS_RQST;
          2'b10: state_next = IDLE;
          2'b00: begin
            state_next = IDLE;
            err_pulse  = 1'b1;
          end
          default: state_next = STOP;
        endcase
      end
      HS_RQST: begin
        case (lp)
          2'b00: state_next = HS_PREP;
          2'b11: state_next = STOP;
          2'b10: begin
            state_next = IDLE;
            err_pulse  = 1'b1;
          end
          default: state_next = HS_RQST;
        endcase
      end
      HS_PREP: begin
        if (lp == 2'b00) begin
          state_next = HS_SETTLE;
        end else begin
          state_next = IDLE;
          err_pulse  = 1'b1;
        end
      end
      HS_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_next  = HS_RX;
          start_pulse = 1'b1;
        end else if (lp == 2'b11) begin
          state_next = STOP;
          err_pulse  = 1'b1;
        end
      end
      HS_RX: begin
        // Stop state on the last allowed cycle still counts as a clean end.
        if (lp == 2'b11) begin
          state_next = STOP;
          end_pulse  = 1'b1;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_next = IDLE;
          err_pulse  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!enable_i) begin
      state_next  = IDLE;
      start_pulse = 1'b0;
      end_pulse   = 1'b0;
      err_pulse   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_in) begin
      state       <= IDLE;
      settle_cnt  <= 8'd0;
      timeout_cnt <= 16'd0;
    end else begin
      state <= state_next;
      if (enable_i) begin
        if (state == HS_PREP) settle_cnt <= 8'd0;
        else if (state == HS_SETTLE) settle_cnt <= settle_cnt + 8'd1;
        if (state != HS_RX) timeout_cnt <= 16'd0;
        else timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_in) begin
      aligner_reset_o <= 1'b1;
      hs_active_o     <= 1'b0;
      hs_start_o      <= 1'b0;
      hs_end_o        <= 1'b0;
      error_o         <= 1'b0;
      burst_count     <= 16'd0;
    end else begin
      aligner_reset_o <= (state_next != HS_RX);
      hs_active_o     <= (state_next == HS_RX);
      hs_start_o      <= start_pulse;
      hs_end_o        <= end_pulse;
      error_o         <= err_pulse;
      if (end_pulse) burst_count <= burst_count + 16'd1;
    end
  end

  assign state_o       = state;
  assign burst_count_o = burst_count;

endmodule

// File: tb/tb_mipi_rx_hs_sequencer.sv
// tb/tb_mipi_rx_hs_sequencer.sv - directed self-checking bench for mipi_rx_hs_sequencer
module tb_mipi_rx_hs_sequencer;

`ifdef MIPI_HS_SEQ_GLITCH_FILTER_EN
  localparam int FL = 3;
`else
  localparam int FL = 0;
`endif
  localparam int HOLD = 5 + FL;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        enable;
  logic        lp_p;
  logic        lp_n;
  logic        aligner_reset;
  logic        hs_active;
  logic        hs_start;
  logic        hs_end;
  logic        error;
  logic [2:0]  state;
  logic [15:0] burst_count;

  int nvec  = 0;
  int nfail = 0;
  int n_start = 0, n_end = 0, n_err = 0, n_alow = 0;
  int s_start = 0, s_end = 0, s_err = 0, s_alow = 0;

  always #5 clk = ~clk;

  mipi_rx_hs_sequencer #(
    .SETTLE_CYCLES (8),
    .TIMEOUT_CYCLES(100),
    .FILTER_CYCLES (3)
  ) dut (
    .clk_i          (clk),
    .reset_in       (reset_in),
    .enable_i       (enable),
    .lp_p_i         (lp_p),
    .lp_n_i         (lp_n),
    .aligner_reset_o(aligner_reset),
    .hs_active_o    (hs_active),
    .hs_start_o     (hs_start),
    .hs_end_o       (hs_end),
    .error_o        (error),
    .state_o        (state),
    .burst_count_o  (burst_count)
  );

  always @(posedge clk) begin
    #2;
    if (hs_start) n_start = n_start + 1;
    if (hs_end) n_end = n_end + 1;
    if (error) n_err = n_err + 1;
    if (!aligner_reset) n_alow = n_alow + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic n);
    lp_p = p;
    lp_n = n;
  endtask

  task automatic snap();
    s_start = n_start;
    s_end   = n_end;
    s_err   = n_err;
    s_alow  = n_alow;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec = nvec + 1;
    assert (obs === exp) else begin
      nfail = nfail + 1;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset_in = 1'b0;
    enable   = 1'b1;
    drive(1'b1, 1'b1);
    tick(4);
    chk("rst_state", 32'(state), 0);
    chk("rst_aligner_reset", 32'(aligner_reset), 1);
    chk("rst_hs_active", 32'(hs_active), 0);
    chk("rst_hs_start", 32'(hs_start), 0);
    chk("rst_hs_end", 32'(hs_end), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_burst_count", 32'(burst_count), 0);
    reset_in = 1'b1;
    tick(HOLD);
    chk("stop_after_reset", 32'(state), 1);

    // Normal burst: 01 then 00 for 20 cycles then 11
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    chk("norm_rqst", 32'(state), 2);
    drive(1'b0, 1'b0);
    tick(12 + FL);
    chk("norm_rx_state", 32'(state), 5);
    chk("norm_rx_aligner", 32'(aligner_reset), 0);
    chk("norm_rx_active", 32'(hs_active), 1);
    tick(8 - FL);
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("norm_state", 32'(state), 1);
    chk("norm_starts", 32'(n_start - s_start), 1);
    chk("norm_ends", 32'(n_end - s_end), 1);
    chk("norm_errors", 32'(n_err - s_err), 0);
    chk("norm_aligner_low", 32'(n_alow - s_alow), 11);
    chk("norm_burst_count", 32'(burst_count), 1);

    // Aborted request
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    chk("abort_rqst", 32'(state), 2);
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("abort_state", 32'(state), 1);
    chk("abort_errors", 32'(n_err - s_err), 0);
    chk("abort_starts", 32'(n_start - s_start), 0);
    chk("abort_burst_count", 32'(burst_count), 1);

    // Illegal entry 11 -> 00
    snap();
    drive(1'b0, 1'b0);
    tick(3 + FL);
    chk("illegal_state", 32'(state), 0);
    chk("illegal_error_pulse", 32'(error), 1);
    chk("illegal_aligner", 32'(aligner_reset), 1);
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("illegal_errors", 32'(n_err - s_err), 1);
    chk("illegal_aligner_low", 32'(n_alow - s_alow), 0);
    chk("illegal_back_stop", 32'(state), 1);

    // Timeout after 100 HS_RX cycles
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    drive(1'b0, 1'b0);
    tick(111 + FL);
    chk("tmo_still_rx", 32'(state), 5);
    tick(1);
    chk("tmo_state", 32'(state), 0);
    chk("tmo_error_pulse", 32'(error), 1);
    chk("tmo_aligner_low", 32'(n_alow - s_alow), 100);
    chk("tmo_burst_count", 32'(burst_count), 1);
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("tmo_errors", 32'(n_err - s_err), 1);

    // LP-11 in the timeout cycle
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    drive(1'b0, 1'b0);
    tick(109);
    drive(1'b1, 1'b1);
    tick(2 + FL);
    chk("coin_still_rx", 32'(state), 5);
    tick(1);
    chk("coin_state", 32'(state), 1);
    chk("coin_hs_end", 32'(hs_end), 1);
    chk("coin_error", 32'(error), 0);
    tick(3);
    chk("coin_errors", 32'(n_err - s_err), 0);
    chk("coin_burst_count", 32'(burst_count), 2);

    // enable low mid-burst
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    drive(1'b0, 1'b0);
    tick(15 + FL);
    chk("en_rx", 32'(state), 5);
    enable = 1'b0;
    tick(1);
    chk("en_state", 32'(state), 0);
    chk("en_aligner", 32'(aligner_reset), 1);
    chk("en_hs_end", 32'(hs_end), 0);
    enable = 1'b1;
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("en_ends", 32'(n_end - s_end), 0);
    chk("en_burst_count", 32'(burst_count), 2);
    chk("en_back_stop", 32'(state), 1);

    // Reset mid-burst
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    drive(1'b0, 1'b0);
    tick(15 + FL);
    reset_in = 1'b0;
    drive(1'b1, 1'b1);
    tick(1);
    chk("rmid_state", 32'(state), 0);
    chk("rmid_burst_count", 32'(burst_count), 0);
    chk("rmid_hs_end", 32'(hs_end), 0);
    chk("rmid_aligner", 32'(aligner_reset), 1);
    reset_in = 1'b1;
    tick(HOLD);
    chk("rmid_stop", 32'(state), 1);

    // Burst counter wrap
    force dut.burst_count = 16'hffff;
    tick(1);
    release dut.burst_count;
    tick(1);
    chk("wrap_preload", 32'(burst_count), 32'h0000ffff);
    snap();
    drive(1'b0, 1'b1);
    tick(HOLD);
    drive(1'b0, 1'b0);
    tick(20);
    drive(1'b1, 1'b1);
    tick(HOLD);
    chk("wrap_burst_count", 32'(burst_count), 0);
    chk("wrap_ends", 32'(n_end - s_end), 1);

`ifdef MIPI_HS_SEQ_GLITCH_FILTER_EN
    drive(1'b0, 1'b1);
    tick(2);
    drive(1'b1, 1'b1);
    tick(10);
    chk("filt_glitch_state", 32'(state), 1);
    drive(1'b0, 1'b1);
    tick(3);
    drive(1'b1, 1'b1);
    tick(3);
    chk("filt_level_state", 32'(state), 2);
    tick(5);
    chk("filt_back_stop", 32'(state), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mipi_rx_hs_sequencer.md
# mipi_rx_hs_sequencer

- Controls HS-burst entry and exit for the MIPI CSI receive path. Watches the LP pair of data lane 0 and walks the D-PHY entry sequence: LP-11 → LP-01 → LP-00 → settle → HS.
- Releases the byte aligners only while a valid HS burst is in progress, and flags aborted or malformed entries and overlong bursts.
- Sits between the DDR/LP input buffers and the `mipi_rx_byte_aligner` instances. It replaces direct use of the raw LP-n line as the aligner reset.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 8: number of `clk_i` cycles spent in HS_SETTLE before the aligners are released. Legal range 1–255.
- `TIMEOUT_CYCLES`, default 65535: maximum number of cycles in HS_RX. Legal range 1–65535.
- `FILTER_CYCLES`, default 2: number of consecutive samples an LP state must hold before it is accepted. Legal range 1–7. Used only with the glitch filter.

Ports:
- `clk_i`, input, 1: byte clock; the single clock of the block.
- `reset_in`, input, 1: reset, synchronous, active-low.
- `enable_i`, input, 1: when low, forces IDLE.
- `lp_p_i`, input, 1: raw LP-p line, asynchronous.
- `lp_n_i`, input, 1: raw LP-n line, asynchronous.
- `aligner_reset_o`, output, 1: active-high reset for the byte aligners.
- `hs_active_o`, output, 1: high while in HS_RX.
- `hs_start_o`, output, 1: one-cycle pulse on entry to HS_RX.
- `hs_end_o`, output, 1: one-cycle pulse on a normal return to stop state.
- `error_o`, output, 1: one-cycle pulse on an illegal sequence or a timeout.
- `state_o`, output, 3: current state encoding.
- `burst_count_o`, output, 16: count of completed bursts; wraps.

## Operation
- Input conditioning:
  - `lp_p_i` and `lp_n_i` each pass through a 2-FF synchronizer.
  - The conditioned value LP = {p,n} feeds the FSM.
- State encoding: IDLE=0, STOP=1, HS_RQST=2, HS_PREP=3, HS_SETTLE=4, HS_RX=5. Encodings 6 and 7 are unreachable; if entered, the FSM goes to IDLE on the next cycle.
- IDLE:
  - LP-11 → STOP.
  - Any other value → stay in IDLE.
- STOP:
  - LP-01 → HS_RQST.
  - LP-10 → IDLE; escape mode is not supported, and this transition raises no error.
  - LP-00 → IDLE and pulse `error_o`.
- HS_RQST:
  - LP-00 → HS_PREP.
  - LP-11 → STOP (abort, no error).
  - LP-10 → IDLE and pulse `error_o`.
- HS_PREP:
  - Lasts exactly one cycle and loads the settle counter with 0.
  - If LP is still 00 → HS_SETTLE.
  - Otherwise → IDLE and pulse `error_o`.
- HS_SETTLE:
  - The counter increments each cycle.
  - When the counter reaches `SETTLE_CYCLES`-1 → HS_RX and pulse `hs_start_o`.
  - LP-11 seen before that → STOP and pulse `error_o`.
- HS_RX:
  - The timeout counter clears on entry and increments every cycle.
  - LP-11 → STOP, pulse `hs_end_o`, `burst_count_o`+1 (wraps 65535→0).
  - Counter reaches `TIMEOUT_CYCLES` → IDLE and pulse `error_o`; `burst_count_o` is not incremented.
  - If LP-11 and the timeout occur in the same cycle, LP-11 wins: normal end.
  - LP-00, LP-01 and LP-10 are ignored. HS swing reads as LP-00.
- `enable_i` low:
  - From any state, the next state is IDLE.
  - All pulses are suppressed, including `hs_end_o` when leaving HS_RX.
  - Counters hold their values; `burst_count_o` is retained.
- Outputs in each state:
  - `aligner_reset_o` = 0 only in HS_RX.
  - `hs_active_o` = 1 only in HS_RX.
  - Both are registered, decoded from the next state, and change in the same cycle as `state_o`.

## Timing
- Reset values (`reset_in` sampled low):
  - state IDLE, `state_o`=0.
  - `aligner_reset_o`=1.
  - `hs_active_o`=0, `hs_start_o`=0, `hs_end_o`=0, `error_o`=0.
  - `burst_count_o`=0.
  - Synchronizer and filter flops cleared to LP-00.
- A reset asserted in the middle of a burst takes effect on the next edge. No `hs_end_o` pulse is produced.
- Latency from a pin change to `state_o`:
  - 3 cycles without the filter: 2 synchronizer cycles plus 1 FSM register.
  - 3 + `FILTER_CYCLES` cycles with the filter.
- Duration from entering HS_PREP to `aligner_reset_o` falling: 1 + `SETTLE_CYCLES` cycles.
- `hs_start_o` is high in the first HS_RX cycle.
- `hs_end_o` and `error_o` are high in the cycle the FSM leaves the state that caused them.
- `hs_start_o` and `hs_end_o` are never asserted in the same cycle.

## Configuration
- Macro: `MIPI_HS_SEQ_GLITCH_FILTER_EN`.
- Defined:
  - Each LP line has a 3-bit stability counter.
  - The accepted LP value updates only after the synchronized value has been unchanged for `FILTER_CYCLES` consecutive cycles.
  - Shorter pulses are discarded.
- Undefined: the synchronizer output feeds the FSM directly, and `FILTER_CYCLES` is ignored.

## Test plan
- Normal burst:
  - Stimulus: LP 11(10 cyc) → 01(5) → 00(20) → 11, with `SETTLE_CYCLES`=8 and the filter off.
  - Required: `hs_start_o` once; `aligner_reset_o` low for exactly 20−1−8=11 cycles; `hs_end_o` once; `burst_count_o`=1; no `error_o`.
- Aborted request:
  - Stimulus: 11 → 01(5) → 11.
  - Required: return to STOP; no `error_o`, no `hs_start_o`; `burst_count_o` unchanged.
- Illegal entry:
  - Stimulus: 11 → 00 directly.
  - Required: `error_o` pulses once; `state_o`=0; `aligner_reset_o` stays 1.
- Timeout:
  - Stimulus: `TIMEOUT_CYCLES`=100, a valid entry, then LP held at 00.
  - Required: `error_o` pulses after 100 HS_RX cycles; `state_o`=0; `burst_count_o` not incremented.
- Wrap and priority:
  - Stimulus: preload via 65535 bursts (or force the counter), then one more burst; separately, LP-11 arriving exactly at timeout.
  - Required: `burst_count_o`=0 after the extra burst; the coincident case yields `hs_end_o` with no `error_o`.
- Filter (macro defined, `FILTER_CYCLES`=3):
  - Stimulus: a 2-cycle LP-01 glitch during STOP.
  - Required: `state_o` stays at 1.
  - Stimulus: a 3-cycle LP-01 level.
  - Required: `state_o` becomes 2.
